// File: rtl/encode81_rr_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared constants and types for the 8-request round-robin encoder.
//   NREQ        number of request lines
//   IDXW        width of a granted index (log2 NREQ)
//   OW          width of the packed output word {idx, valid}
//   state_t     two-state grant FSM encoding
//   O_VALID_BIT bit position of the valid flag in the packed word
//   O_IDX_LSB   LSB position of the index field in the packed word
// -----------------------------------------------------------------------------
package enc_pkg;

    localparam int NREQ        = 8;
    localparam int IDXW        = 3;
    localparam int OW          = IDXW + 1;
    localparam int O_VALID_BIT = 0;
    localparam int O_IDX_LSB   = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Build the packed select word that the downstream 1-to-8 demux decodes.
    function automatic logic [OW-1:0] pack_grant(input logic [IDXW-1:0] idx);
        logic [OW-1:0] w;
        w                         = '0;
        w[O_IDX_LSB +: IDXW]      = idx;
        w[O_VALID_BIT]            = 1'b1;
        return w;
    endfunction

endpackage : enc_pkg

// File: rtl/encode81_rr_if.sv
// -----------------------------------------------------------------------------
// encode81_rr_if
// Request/grant bundle between a requesting agent and the round-robin encoder.
//   en     agent -> encoder  new grants may start
//   req    agent -> encoder  level-sensitive request lines
//   ack    agent -> encoder  consumer accepts the current grant
//   o      encoder -> agent  packed {idx, valid}
//   multi  encoder -> agent  more than one request seen at the producing arbitration
// master modport: the side driving requests; slave modport: the encoder.
// -----------------------------------------------------------------------------
interface encode81_rr_if;
    import enc_pkg::*;

    logic              en;
    logic [NREQ-1:0]   req;
    logic              ack;
    logic [OW-1:0]     o;
    logic              multi;

    modport master (
        output en,
        output req,
        output ack,
        input  o,
        input  multi
    );

    modport slave (
        input  en,
        input  req,
        input  ack,
        output o,
        output multi
    );

endinterface : encode81_rr_if

// File: rtl/encode81_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector.
//   req_i    request lines
//   ptr_i    highest-priority position for this arbitration
//   any_o    at least one request is set
//   idx_o    first set request scanning ptr, ptr+1, ... ptr+7 (mod NREQ)
//   multi_o  more than one request is set
// The requests are rotated so that position ptr lands on bit 0, a fixed
// LSB-first priority search finds the offset, and ptr is added back.
// -----------------------------------------------------------------------------
module rr_pick
    import enc_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic            any_o,
    output logic [IDXW-1:0] idx_o,
    output logic            multi_o
);

    logic [NREQ-1:0] rot;
    logic [IDXW-1:0] offset;

    // rot[j] = req[(j + ptr) mod 8]; the 3-bit add wraps naturally.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDXW-1:0] src_idx;
            assign src_idx = IDXW'(gi) + ptr_i;
            assign rot[gi] = req_i[src_idx];
        end
    endgenerate

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        offset = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = IDXW'(i);
            end
        end
    end

    assign idx_o   = offset + ptr_i;
    assign any_o   = |req_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o = |(req_i & (req_i - NREQ'(1)));

endmodule : rr_pick

// File: rtl/encode81_rr.sv
// -----------------------------------------------------------------------------
// encode81_rr
// 8-request round-robin encoder. Grants one requester at a time and presents
// it as the packed select word {idx[2:0], valid}; the grant is held bit-stable
// until acknowledged, after which the priority pointer moves past the winner.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   encode81_rr_if.slave: en, req, ack in; o, multi out
// An acknowledge with requests still pending reloads a new grant in the same
// cycle (back-to-back), arbitrated from the already-advanced pointer.
// -----------------------------------------------------------------------------
module encode81_rr
    import enc_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    encode81_rr_if.slave   bus
);

    state_t          state_q;
    logic [IDXW-1:0] ptr_q;
    logic [OW-1:0]   o_q;
    logic            multi_q;

    logic [IDXW-1:0] cur_idx;
    logic [IDXW-1:0] ptr_d;
    logic            ack_fire;
    logic [IDXW-1:0] pick_ptr;
    logic            pick_any;
    logic [IDXW-1:0] pick_idx;
    logic            pick_multi;
    logic            start;

    // The granted index lives only in the output register.
    assign cur_idx  = o_q[O_IDX_LSB +: IDXW];
    assign ptr_d    = cur_idx + IDXW'(1);
    assign ack_fire = (state_q == ST_GRANT) && bus.ack;

    // On an accepted grant the next arbitration must already see the moved
    // pointer, otherwise back-to-back service would favour the old winner.
    assign pick_ptr = ack_fire ? ptr_d : ptr_q;

    rr_pick u_pick (
        .req_i   (bus.req),
        .ptr_i   (pick_ptr),
        .any_o   (pick_any),
        .idx_o   (pick_idx),
        .multi_o (pick_multi)
    );

    assign start = bus.en && pick_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            o_q     <= '0;
            multi_q <= 1'b0;
        end else begin
            // multi is a one-cycle marker on the first cycle of a grant.
            multi_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        o_q     <= pack_grant(pick_idx);
                        multi_q <= pick_multi;
                        state_q <= ST_GRANT;
                    end else begin
                        o_q     <= '0;
                    end
                end
                ST_GRANT: begin
                    if (bus.ack) begin
                        ptr_q <= ptr_d;
                        if (start) begin
                            o_q     <= pack_grant(pick_idx);
                            multi_q <= pick_multi;
                        end else begin
                            o_q     <= '0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    o_q     <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o     = o_q;
    assign bus.multi = multi_q;

endmodule : encode81_rr

// File: tb/tb_encode81_rr.sv
// -----------------------------------------------------------------------------
// tb_encode81_rr
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the encoder built from its arbitration rules.
// -----------------------------------------------------------------------------
module tb_encode81_rr;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    encode81_rr_if bus ();

    encode81_rr dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    bit       m_busy;
    int       m_ptr;
    int       m_idx;
    bit [3:0] m_o;
    bit       m_multi;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester found walking upward from p, wrapping at 8.
    function automatic int first_from(input bit [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return 0;
    endfunction

    task automatic model_grant(input bit [7:0] r);
        m_idx   = first_from(r, m_ptr);
        m_o     = 4'((m_idx << 1) | 1);
        m_multi = ($countones(r) > 1);
        m_busy  = 1'b1;
    endtask

    task automatic model_edge(input bit r_rst, input bit en, input bit [7:0] r, input bit ack);
        if (r_rst) begin
            m_busy = 0; m_ptr = 0; m_o = 0; m_multi = 0;
        end else if (!m_busy) begin
            m_multi = 0;
            if (en && r != 0) model_grant(r);
            else m_o = 0;
        end else begin
            m_multi = 0;
            if (ack) begin
                $display("txn: grant idx=%0d accepted, ptr -> %0d", m_idx, (m_idx + 1) % 8);
                m_ptr = (m_idx + 1) % 8;
                if (en && r != 0) model_grant(r);
                else begin
                    m_o = 0; m_busy = 0;
                end
            end
        end
    endtask

    // One clock: drive at negedge, model at posedge, sample 1 time unit later.
    task automatic step(input bit r_rst, input bit en, input bit [7:0] r, input bit ack);
        @(negedge clk);
        rst     = r_rst;
        bus.en  = en;
        bus.req = r;
        bus.ack = ack;
        @(posedge clk);
        model_edge(r_rst, en, r, ack);
        #1;
        chk("o",     bus.o,       m_o);
        chk("multi", bus.multi,   m_multi);
        chk("ptr",   dut.ptr_q,   m_ptr);
    endtask

    initial begin
        bit [7:0] r;
        bit       en, ack, rr;
        rst = 1'b1; bus.en = 1'b0; bus.req = '0; bus.ack = 1'b0;

        // 1: reset dominates all inputs
        step(1, 1, 8'hFF, 0);
        chk("t1_o0", bus.o, 0);
        step(1, 1, 8'hFF, 1);
        chk("t1_o1", bus.o, 0);
        chk("t1_multi", bus.multi, 0);

        // 2: single request, long hold, ack moves ptr past winner
        step(0, 1, 8'b0010_0000, 0);
        chk("t2_grant", bus.o, 4'b1011);
        chk("t2_multi", bus.multi, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 8'h00, 0);
            chk("t2_hold", bus.o, 4'b1011);
        end
        step(0, 1, 8'h00, 1);
        chk("t2_ack_o", bus.o, 0);
        chk("t2_ptr", dut.ptr_q, 6);

        // 3: all requesting with continuous ack rotates through every index
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 8'hFF, 1);
            chk("t3_idx", bus.o[3:1], i % 8);
            chk("t3_valid", bus.o[0], 1);
            chk("t3_multi", bus.multi, 1);
        end
        step(0, 1, 8'h00, 1);
        chk("t3_end", bus.o, 0);

        // 4: pointer wrap from 7 to 0
        step(0, 1, 8'h40, 0);
        chk("t4_g6", bus.o, 4'b1101);
        step(0, 1, 8'h00, 1);
        chk("t4_ptr7", dut.ptr_q, 7);
        step(0, 1, 8'b0000_0011, 0);
        chk("t4_wrap", bus.o, 4'b0001);
        chk("t4_multi", bus.multi, 1);
        step(0, 1, 8'b0000_0011, 1);
        chk("t4_ptr1", dut.ptr_q, 1);
        chk("t4_next", bus.o, 4'b0011);
        step(0, 1, 8'h00, 1);

        // 5: enable gating and ack edge cases
        step(0, 0, 8'h08, 0);
        chk("t5_en0", bus.o, 0);
        step(0, 1, 8'h08, 0);
        chk("t5_en1", bus.o, 4'b0111);
        step(0, 0, 8'h08, 0);
        chk("t5_hold", bus.o, 4'b0111);
        step(0, 0, 8'h08, 1);
        chk("t5_noreload", bus.o, 0);
        step(0, 0, 8'h00, 1);
        chk("t5_idle_ack", bus.o, 0);
        chk("t5_idle_ptr", dut.ptr_q, 4);

        // 6: reset in the middle of a grant
        step(0, 1, 8'h40, 0);
        chk("t6_grant", bus.o, 4'b1101);
        step(1, 1, 8'h40, 0);
        chk("t6_rst_o", bus.o, 0);
        chk("t6_rst_ptr", dut.ptr_q, 0);
        step(0, 1, 8'h80, 0);
        chk("t6_after", bus.o, 4'b1111);
        step(0, 1, 8'h00, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rr  = ($urandom_range(0, 63) == 0);
            en  = ($urandom_range(0, 9) < 8);
            ack = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       r = 8'h00;
                1:       r = 8'(1 << $urandom_range(0, 7));
                default: r = 8'($urandom);
            endcase
            step(rr, en, r, ack);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_encode81_rr
